coin_accumulator: RTL and testbench
===================================

Name: coin_accumulator

Overview:
Consumer of the debounced step_option / hold_option codes produced by the button debouncer. Turns debounced button levels into coin-add events with press-edge detection and press-and-hold auto-repeat. Maintains a saturating running total for the display path. Applies hold codes as clear/freeze controls.

Parameters:
TOTAL_W, 16, width of the total register
MAX_TOTAL, 9999, saturation ceiling (4-digit display); must be < 2**TOTAL_W
VAL_U, 1, coin value for step code 4'b0001
VAL_L, 5, coin value for step code 4'b0010
VAL_R, 10, coin value for step code 4'b0100
VAL_D, 25, coin value for step code 4'b1000
REPEAT_DELAY, 50000000, cycles a code must stay held after its first add before auto-repeat begins
REPEAT_PERIOD, 10000000, cycles between auto-repeat adds
CNT_W, $clog2(REPEAT_DELAY+1), repeat counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
step_option  in  4  debounced one-hot coin code; 0 = no button
hold_option  in  3  debounced hold code: 001 = freeze, 010 = clear, 000 = normal
total  out  TOTAL_W  accumulated coin total
saturated  out  1  sticky: an add was clipped at MAX_TOTAL
add_pulse  out  1  one-cycle strobe for each applied add
repeating  out  1  high while the FSM is in REPEAT

Behaviour:
- Clocking/reset: one clock (clk); rst is asynchronous, active-high.
- Reset values: total=0, saturated=0, add_pulse=0, repeating=0, FSM=IDLE, step_prev=0, counter=0.
- Legal step codes: 0001, 0010, 0100, 1000. Any other code, including multi-hot, is treated as 0000 (release).
- step_prev registers the legalised code every cycle.
- Press event: code is nonzero and differs from step_prev.
- Latency: a press sampled at edge k updates total at edge k and drives add_pulse high for exactly the cycle after edge k.
- FSM states:
  - IDLE: on a press event, add value and go to PRESSED with counter=0.
  - PRESSED: counter increments each cycle. When counter == REPEAT_DELAY-1, add value, clear counter and go to REPEAT.
  - REPEAT: counter increments each cycle. When counter == REPEAT_PERIOD-1, add value and clear counter. repeating=1 in this state.
  - From PRESSED or REPEAT: code 0 returns to IDLE with no add. A different legal code is a press event: add the new value, go to PRESSED, counter=0.
- Hold priority: clear (bit1) > freeze (bit0) > normal. Codes 011 and 1xx obey the bit priority.
  - Clear: total=0, saturated=0, FSM forced to IDLE, no add_pulse. step_prev still tracks.
  - Freeze: total and saturated held, FSM forced to IDLE, no adds. step_prev still tracks.
  - In both cases a button held across the hold release adds nothing until it is released and pressed again.
- Arithmetic: sum computed at TOTAL_W+1 bits.
  - If sum > MAX_TOTAL: total=MAX_TOTAL and saturated=1. add_pulse still fires.
  - saturated clears only on clear or rst. total never wraps.
- Simultaneous events: a press arriving in the same cycle as a clear or freeze is discarded.
- A press arriving while the timer expiry would fire counts as one add only; the press wins.
- Reset asserted mid-repeat: all state returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package coin_pkg holds:
  - FSM state enum: IDLE, PRESSED, REPEAT.
  - Step code constants: STEP_U, STEP_L, STEP_R, STEP_D.
  - Hold bit indices: HOLD_FREEZE=0, HOLD_CLEAR=1.
  - Default coin values.
- One sub-module, repeat_timer: counter with clear/enable, terminal-count compare selected between DELAY and PERIOD, and an expiry strobe.
- Code legalisation, value lookup and the saturating adder stay in the top level.

Test Plan:
All scenarios use REPEAT_DELAY=8, REPEAT_PERIOD=4, MAX_TOTAL=99.
- Reset state and single press: after rst, total=0 and saturated=0. Apply step 0001 for 3 cycles then 0000 → total=1, exactly one add_pulse, pulse one cycle after the code appears.
- Auto-repeat: hold 1000 for 20 cycles → adds at cycles 0, 8, 12, 16. total=100 clips to 99, saturated=1, repeating=1 from cycle 8. Release → IDLE.
- Code change while held: 0010 for 3 cycles, then 0100 → total=5, then 15 on the change cycle, counter restarted.
- Illegal code: step 0011 → no add. Then 0001 → treated as a new press, total +1.
- Hold controls:
  - Freeze 001 while pressing 1000 → total unchanged. Release freeze with button still held → no add.
  - Clear 010 → total=0 and saturated=0 on the next edge.
- Async reset: assert rst mid-REPEAT between clock edges → total=0 and repeating=0 before the next edge.

Source files
------------

// File: rtl/coin_accumulator_pkg.sv
// Shared types and constants for the coin accumulator: FSM states,
// legal one-hot step codes, hold-bit positions and default coin values.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [3:0] STEP_U = 4'b0001;
  localparam logic [3:0] STEP_L = 4'b0010;
  localparam logic [3:0] STEP_R = 4'b0100;
  localparam logic [3:0] STEP_D = 4'b1000;

  localparam int HOLD_FREEZE = 0;
  localparam int HOLD_CLEAR  = 1;

  localparam int DEF_VAL_U = 1;
  localparam int DEF_VAL_L = 5;
  localparam int DEF_VAL_R = 10;
  localparam int DEF_VAL_D = 25;

endpackage

// File: rtl/coin_accumulator_if.sv
// Button-code inputs and total/status outputs of the coin accumulator.
// The debouncer side is the master; the accumulator is the slave.
interface coin_accumulator_if #(
  parameter int TOTAL_W = 16
);
  logic [3:0]         step_option;
  logic [2:0]         hold_option;
  logic [TOTAL_W-1:0] total;
  logic               saturated;
  logic               add_pulse;
  logic               repeating;

  modport master (
    output step_option, hold_option,
    input  total, saturated, add_pulse, repeating
  );

  modport slave (
    input  step_option, hold_option,
    output total, saturated, add_pulse, repeating
  );
endinterface

// File: rtl/coin_accumulator_repeat_timer.sv
// Press-and-hold timer: counts cycles while enabled and strobes o_expire
// when the selected terminal count (initial delay or repeat period) is hit.
// The owner is expected to clear the counter on every expiry.
module repeat_timer #(
  parameter int DELAY  = 50000000,
  parameter int PERIOD = 10000000,
  parameter int CNT_W  = $clog2(DELAY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_sel_period,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_tc;

  assign w_tc     = i_sel_period ? PERIOD_TC : DELAY_TC;
  assign o_expire = i_enable && (r_count == w_tc);

  // Cycle counter: clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: turns debounced one-hot button codes into coin adds
// (press edge plus press-and-hold auto-repeat) on a saturating total,
// with clear/freeze hold controls taking priority over button activity.
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int TOTAL_W       = 16,
  parameter int MAX_TOTAL     = 9999,
  parameter int VAL_U         = DEF_VAL_U,
  parameter int VAL_L         = DEF_VAL_L,
  parameter int VAL_R         = DEF_VAL_R,
  parameter int VAL_D         = DEF_VAL_D,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = $clog2(REPEAT_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  coin_accumulator_if.slave bus
);

  localparam logic [TOTAL_W:0]   MAX_EXT = (TOTAL_W + 1)'(MAX_TOTAL);
  localparam logic [TOTAL_W-1:0] MAX_TOT = TOTAL_W'(MAX_TOTAL);

  state_t             r_state;
  logic [3:0]         r_step_prev;
  logic [TOTAL_W-1:0] r_total;
  logic               r_saturated;
  logic               r_add_pulse;
  logic               r_repeating;

  logic [3:0]         w_code;
  logic [TOTAL_W:0]   w_value;
  logic [TOTAL_W:0]   w_sum;
  logic               w_sat_hit;
  logic [TOTAL_W-1:0] w_total_add;
  logic               w_press;
  logic               w_hold_clear;
  logic               w_hold_freeze;
  logic               w_active;
  logic               w_expire;
  logic               w_tmr_clear;

  // Legalise the step code: anything but a single recognised bit is a release.
  always_comb begin
    w_code = 4'b0000;
    case (bus.step_option)
      STEP_U, STEP_L, STEP_R, STEP_D: w_code = bus.step_option;
      default:                        w_code = 4'b0000;
    endcase
  end

  // Coin value of the legalised code, sized for the widened adder.
  always_comb begin
    w_value = '0;
    case (w_code)
      STEP_U:  w_value = (TOTAL_W + 1)'(VAL_U);
      STEP_L:  w_value = (TOTAL_W + 1)'(VAL_L);
      STEP_R:  w_value = (TOTAL_W + 1)'(VAL_R);
      STEP_D:  w_value = (TOTAL_W + 1)'(VAL_D);
      default: w_value = '0;
    endcase
  end

  // Decode hold code by bit priority: clear beats freeze; bit 2 is ignored.
  always_comb begin
    w_hold_clear  = 1'b0;
    w_hold_freeze = 1'b0;
    casez (bus.hold_option)
      3'b?1?:  w_hold_clear  = 1'b1;
      3'b??1:  w_hold_freeze = 1'b1;
      default: begin
        w_hold_clear  = 1'b0;
        w_hold_freeze = 1'b0;
      end
    endcase
  end

  // The extra sum bit lets us detect overshoot without ever wrapping.
  assign w_sum       = {1'b0, r_total} + w_value;
  assign w_sat_hit   = (w_sum > MAX_EXT);
  assign w_total_add = w_sat_hit ? MAX_TOT : w_sum[TOTAL_W-1:0];

  assign w_press  = (w_code != 4'b0000) && (w_code != r_step_prev);
  assign w_active = (r_state != IDLE);

  // Restart the timer whenever the hold sequence is (re)started or abandoned.
  assign w_tmr_clear = w_hold_clear || w_hold_freeze || !w_active ||
                       (w_code == 4'b0000) || w_press || w_expire;

  repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_tmr_clear),
    .i_enable     (w_active),
    .i_sel_period (r_state == REPEAT),
    .o_expire     (w_expire)
  );

  // Control FSM with registered total, saturation flag and status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step_prev <= 4'b0000;
      r_total     <= '0;
      r_saturated <= 1'b0;
      r_add_pulse <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_step_prev <= w_code;
      r_add_pulse <= 1'b0;
      if (w_hold_clear) begin
        r_total     <= '0;
        r_saturated <= 1'b0;
        r_state     <= IDLE;
        r_repeating <= 1'b0;
      end else if (w_hold_freeze) begin
        r_state     <= IDLE;
        r_repeating <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_press) begin
              r_total     <= w_total_add;
              r_saturated <= r_saturated | w_sat_hit;
              r_add_pulse <= 1'b1;
              r_state     <= PRESSED;
              r_repeating <= 1'b0;
            end
          end
          PRESSED, REPEAT: begin
            if (w_code == 4'b0000) begin
              r_state     <= IDLE;
              r_repeating <= 1'b0;
            end else if (w_press) begin
              // A fresh press outranks a coincident timer expiry.
              r_total     <= w_total_add;
              r_saturated <= r_saturated | w_sat_hit;
              r_add_pulse <= 1'b1;
              r_state     <= PRESSED;
              r_repeating <= 1'b0;
            end else if (w_expire) begin
              r_total     <= w_total_add;
              r_saturated <= r_saturated | w_sat_hit;
              r_add_pulse <= 1'b1;
              r_state     <= REPEAT;
              r_repeating <= 1'b1;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_repeating <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.total     = r_total;
  assign bus.saturated = r_saturated;
  assign bus.add_pulse = r_add_pulse;
  assign bus.repeating = r_repeating;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: directed vector table, a hand-written
// asynchronous-reset sequence, then random stimulus against a model.
module tb_coin_accumulator;

  localparam int TW     = 16;
  localparam int MAXT   = 99;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;

  logic clk;
  logic rst;

  coin_accumulator_if #(.TOTAL_W(TW)) bus ();

  coin_accumulator #(
    .TOTAL_W       (TW),
    .MAX_TOTAL     (MAXT),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_PERIOD (PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  typedef struct {
    logic [3:0] s;
    logic [2:0] h;
    int         t;
    bit         sat;
    bit         p;
    bit         r;
  } vec_t;

  vec_t vecs[$];

  // Reference model: tracks adds by "cycles since the last add" and how many
  // adds the current uninterrupted hold has produced.
  int         m_total;
  bit         m_sat;
  logic [3:0] m_prev;
  bit         m_active;
  int         m_since;
  int         m_run_adds;
  bit         m_pulse;
  bit         m_rep;

  function automatic logic [3:0] legal(input logic [3:0] c);
    if (c == 4'd1 || c == 4'd2 || c == 4'd4 || c == 4'd8) return c;
    return 4'd0;
  endfunction

  function automatic int coin_val(input logic [3:0] c);
    case (c)
      4'd1:    return 1;
      4'd2:    return 5;
      4'd4:    return 10;
      4'd8:    return 25;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_total = 0; m_sat = 0; m_prev = 4'd0; m_active = 0;
    m_since = 0; m_run_adds = 0; m_pulse = 0; m_rep = 0;
  endtask

  task automatic model_add(input logic [3:0] c);
    m_total = m_total + coin_val(c);
    if (m_total > MAXT) begin
      m_total = MAXT;
      m_sat   = 1;
    end
    m_pulse = 1;
  endtask

  task automatic model_edge(input logic [3:0] s, input logic [2:0] h);
    logic [3:0] c;
    c = legal(s);
    m_pulse = 0;
    if (h[1]) begin
      m_total = 0; m_sat = 0; m_active = 0;
    end else if (h[0]) begin
      m_active = 0;
    end else if (c != 4'd0 && c != m_prev) begin
      model_add(c);
      m_active = 1; m_since = 0; m_run_adds = 1;
    end else if (c == 4'd0) begin
      m_active = 0;
    end else if (m_active) begin
      m_since++;
      if (m_since == ((m_run_adds == 1) ? DELAY : PERIOD)) begin
        model_add(c);
        m_since = 0;
        m_run_adds++;
      end
    end
    m_prev = c;
    m_rep  = m_active && (m_run_adds >= 2);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input bit s, input bit p, input bit r);
    chk({tag, ".total"},     32'(bus.total),     32'(t));
    chk({tag, ".saturated"}, 32'(bus.saturated), 32'(s));
    chk({tag, ".add_pulse"}, 32'(bus.add_pulse), 32'(p));
    chk({tag, ".repeating"}, 32'(bus.repeating), 32'(r));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic apply(input logic [3:0] s, input logic [2:0] h);
    bus.step_option = s;
    bus.hold_option = h;
    @(posedge clk);
    model_edge(s, h);
    #1;
  endtask

  task automatic v(input logic [3:0] s, input logic [2:0] h, input int t,
                   input bit sat, input bit p, input bit r, input int n = 1);
    vec_t e;
    e.s = s; e.h = h; e.t = t; e.sat = sat; e.p = p; e.r = r;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  initial begin
    logic [3:0] r_code;
    logic [2:0] r_hold;
    int         run_left;

    n_total = 0;
    n_bad   = 0;
    model_reset();

    // Single press, then release
    v(4'd1, 3'd0, 1, 0, 1, 0);
    v(4'd1, 3'd0, 1, 0, 0, 0, 2);
    v(4'd0, 3'd0, 1, 0, 0, 0);
    // Clear, then hold 1000 for 20 cycles: adds at 0, 8, 12, 16; clip at 99
    v(4'd0, 3'd2, 0, 0, 0, 0);
    v(4'd8, 3'd0, 25, 0, 1, 0);
    v(4'd8, 3'd0, 25, 0, 0, 0, 7);
    v(4'd8, 3'd0, 50, 0, 1, 1);
    v(4'd8, 3'd0, 50, 0, 0, 1, 3);
    v(4'd8, 3'd0, 75, 0, 1, 1);
    v(4'd8, 3'd0, 75, 0, 0, 1, 3);
    v(4'd8, 3'd0, 99, 1, 1, 1);
    v(4'd8, 3'd0, 99, 1, 0, 1, 3);
    v(4'd0, 3'd0, 99, 1, 0, 0);
    // Clear drops saturation
    v(4'd0, 3'd2, 0, 0, 0, 0);
    // Code change while held restarts the delay
    v(4'd2, 3'd0, 5, 0, 1, 0);
    v(4'd2, 3'd0, 5, 0, 0, 0, 2);
    v(4'd4, 3'd0, 15, 0, 1, 0);
    v(4'd4, 3'd0, 15, 0, 0, 0, 7);
    v(4'd4, 3'd0, 25, 0, 1, 1);
    v(4'd0, 3'd0, 25, 0, 0, 0);
    // Illegal codes are releases
    v(4'd3, 3'd0, 25, 0, 0, 0);
    v(4'd1, 3'd0, 26, 0, 1, 0);
    v(4'd12, 3'd0, 26, 0, 0, 0);
    v(4'd15, 3'd0, 26, 0, 0, 0);
    // Freeze while pressing; held button across release adds nothing
    v(4'd8, 3'd1, 26, 0, 0, 0, 3);
    v(4'd8, 3'd0, 26, 0, 0, 0, 10);
    v(4'd0, 3'd0, 26, 0, 0, 0);
    v(4'd8, 3'd0, 51, 0, 1, 0);
    v(4'd0, 3'd0, 51, 0, 0, 0);
    // Hold code 011 acts as clear; press in the same cycle is discarded
    v(4'd4, 3'd3, 0, 0, 0, 0);
    v(4'd4, 3'd0, 0, 0, 0, 0);
    v(4'd0, 3'd0, 0, 0, 0, 0);
    // Press coinciding with delay expiry counts once
    v(4'd1, 3'd0, 1, 0, 1, 0);
    v(4'd1, 3'd0, 1, 0, 0, 0, 7);
    v(4'd2, 3'd0, 6, 0, 1, 0);
    v(4'd2, 3'd0, 6, 0, 0, 0);
    v(4'd0, 3'd0, 6, 0, 0, 0);
    // Freeze while repeating drops repeating
    v(4'd8, 3'd0, 31, 0, 1, 0);
    v(4'd8, 3'd0, 31, 0, 0, 0, 7);
    v(4'd8, 3'd0, 56, 0, 1, 1);
    v(4'd8, 3'd1, 56, 0, 0, 0);
    v(4'd8, 3'd0, 56, 0, 0, 0);
    v(4'd0, 3'd0, 56, 0, 0, 0);
    // Hold 100 has neither control bit: normal operation
    v(4'd1, 3'd4, 57, 0, 1, 0);
    v(4'd0, 3'd0, 57, 0, 0, 0);

    bus.step_option = 4'd0;
    bus.hold_option = 3'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].s, vecs[i].h);
      chk_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].sat, vecs[i].p, vecs[i].r);
      $display("vec %0d step=%b hold=%b total=%0d sat=%0b pulse=%0b rep=%0b",
               i, vecs[i].s, vecs[i].h, bus.total, bus.saturated, bus.add_pulse, bus.repeating);
    end

    // Asynchronous reset in the middle of REPEAT
    apply(4'd0, 3'd2);
    for (int i = 0; i < 10; i++) apply(4'd8, 3'd0);
    chk_all("pre_async", 50, 0, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    $display("async reset mid-repeat total=%0d rep=%0b", bus.total, bus.repeating);
    bus.step_option = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random phase against the model
    run_left = 0;
    r_code   = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 2)      r_code = 4'd0;
        else if (sel < 8) r_code = 4'b0001 << $urandom_range(0, 3);
        else              r_code = 4'($urandom_range(0, 15));
        run_left = $urandom_range(1, 30);
      end
      run_left--;
      r_hold = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      apply(r_code, r_hold);
      chk_all($sformatf("rnd%0d", i), m_total, m_sat, m_pulse, m_rep);
      $display("rnd %0d step=%b hold=%b total=%0d exp=%0d pulse=%0b rep=%0b",
               i, r_code, r_hold, bus.total, m_total, bus.add_pulse, bus.repeating);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
